conv_window_ctrl: RTL
=====================

CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8: pixel width in bits.
REQ-002 SHALL have parameter MAX_WIDTH, default 512: maximum image width, equal to the line-buffer MAX_DEPTH.
REQ-003 SHALL have parameter MAX_HEIGHT, default 512: maximum image height.
REQ-004 SHALL have port i_clk, input, 1: sole clock; all state changes on its rising edge.
REQ-005 SHALL have port i_reset, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port i_start, input, 1: start-frame pulse; sampled only in IDLE.
REQ-007 SHALL have port i_cfg_width, input, $clog2(MAX_WIDTH)+1: frame width in pixels.
REQ-008 SHALL have port i_cfg_height, input, $clog2(MAX_HEIGHT)+1: frame height in rows.
REQ-009 SHALL have port i_abort, input, 1: abandon the frame, return to IDLE.
REQ-010 SHALL have port i_px_valid, input, 1: input pixel valid.
REQ-011 SHALL have port i_px_data, input, DATA_W: input pixel.
REQ-012 SHALL have port o_px_ready, output, 1: pixel accepted this cycle when high with i_px_valid.
REQ-013 SHALL have port o_lb_load_depth, output, 1: line-buffer depth-load pulse.
REQ-014 SHALL have port o_lb_depth, output, $clog2(MAX_WIDTH)+1: depth value to load.
REQ-015 SHALL have port o_lb_wr_valid, output, 1: line-buffer write strobe.
REQ-016 SHALL have port o_lb_wr_data, output, DATA_W: line-buffer write data.
REQ-017 SHALL have port o_win_valid, output, 1: a complete 3x3 window is present.
REQ-018 SHALL have port o_win_col, output, $clog2(MAX_WIDTH): window bottom-right column.
REQ-019 SHALL have port o_win_row, output, $clog2(MAX_HEIGHT): window bottom-right row.
REQ-020 SHALL have port o_busy, output, 1: high whenever the FSM is not in IDLE.
REQ-021 SHALL have port o_done, output, 1: one-cycle frame-complete pulse.
REQ-022 SHALL have port o_cfg_err, output, 1: one-cycle configuration-rejected pulse.

Function
REQ-023 SHALL implement the FSM states IDLE, LOAD, RUN, DONE.
REQ-024 SHALL, in IDLE on i_start, latch the width and height and go to LOAD if 3<=width<=MAX_WIDTH and 3<=height<=MAX_HEIGHT.
REQ-025 SHALL, when i_start arrives with an invalid configuration, pulse o_cfg_err for one cycle and stay in IDLE.
REQ-026 SHALL, in LOAD, assert o_lb_load_depth for exactly one cycle with o_lb_depth equal to the latched width, then go to RUN.
REQ-027 SHALL drive o_px_ready high only in RUN.
REQ-028 SHALL define acceptance as i_px_valid && o_px_ready.
REQ-029 SHALL make o_lb_wr_valid and o_lb_wr_data combinational copies of acceptance and i_px_data, so they carry zero latency.
REQ-030 SHALL, on each acceptance, increment the column counter; at width-1 the column wraps to 0 and the row increments.
REQ-031 SHALL, on the acceptance at col=width-1 and row=height-1, go to DONE, so that no further pixel is accepted that cycle onward.
REQ-032 SHALL, in DONE, pulse o_done for one cycle and then return to IDLE.
REQ-033 SHALL register o_win_valid one cycle after an acceptance whose row>=2 and col>=2, which aligns it with the line-buffer o_rd_valid.
REQ-034 SHALL register o_win_col and o_win_row with the coordinates of that accepted pixel, and hold them otherwise.
REQ-035 SHALL produce exactly (width-2)*(height-2) o_win_valid pulses per completed frame.
REQ-036 SHALL leave the counters unchanged on a cycle where i_px_valid is low.
REQ-037 SHALL, on i_abort in any state, go to IDLE next cycle, clear the counters, and suppress o_done and o_win_valid.
REQ-038 SHALL give i_abort priority over a simultaneous final acceptance.
REQ-039 SHALL ignore i_start while not in IDLE.

Reset
REQ-040 SHALL, on i_reset, enter IDLE, zero the counters, drive all outputs to 0 and o_lb_depth to MAX_WIDTH.
REQ-041 SHALL give i_reset priority over i_abort and i_start.
REQ-042 SHALL, on reset mid-RUN, produce no o_done pulse.

Structure
REQ-043 SHALL place the FSM state enum and width helper constants in the shared package conv_pkg.
REQ-044 SHALL implement the column/row counter as one sub-module, frame_counter, which outputs col, row and last.

Verification
REQ-045 SHALL verify: a 4x4 frame with continuous valid -> one load pulse with depth 4, 16 writes, 4 window pulses at (2,2),(3,2),(2,3),(3,3), then o_done.
REQ-046 SHALL verify: a 5x3 frame with i_px_valid toggled every other cycle -> 3 window pulses, each one cycle after its acceptance.
REQ-047 SHALL verify: i_start with width=2 or height=600 (MAX 512) -> o_cfg_err pulse, o_busy stays 0, no load pulse.
REQ-048 SHALL verify: i_abort asserted together with the final pixel of a 3x3 frame -> no o_done, IDLE next cycle, and the next 3x3 frame yields exactly 1 window.
REQ-049 SHALL verify: i_reset at pixel 7 of an 8x8 frame -> all outputs 0 next cycle, o_lb_depth=512, no o_done.
REQ-050 SHALL verify: i_start pulsed during RUN -> ignored, and the frame completes with the original configuration.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared FSM state type and sizing helpers for the 3x3 window controller.
package conv_pkg;

   // Frame-level controller states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } conv_state_t;

   // Window edge length; also the smallest legal frame dimension.
   localparam int WIN_SIZE = 3;

   // Bits needed for a coordinate in the range 0 .. max_val-1.
   function automatic int cnt_bits(input int max_val);
      return $clog2(max_val);
   endfunction

   // Bits needed for a dimension in the range 0 .. max_val.
   function automatic int cfg_bits(input int max_val);
      return $clog2(max_val) + 1;
   endfunction

endpackage

// File: rtl/frame_counter.sv
// Column/row raster counter; wraps at the configured frame size.
module frame_counter import conv_pkg::*; #(
   parameter int MAX_WIDTH  = 512,
   parameter int MAX_HEIGHT = 512
) (
   input  logic                            i_clk,
   input  logic                            i_reset,
   input  logic                            i_clear,
   input  logic                            i_advance,
   input  logic [cfg_bits(MAX_WIDTH)-1:0]  i_width,
   input  logic [cfg_bits(MAX_HEIGHT)-1:0] i_height,
   output logic [cnt_bits(MAX_WIDTH)-1:0]  o_col,
   output logic [cnt_bits(MAX_HEIGHT)-1:0] o_row,
   output logic                            o_last
);

   localparam int WW = cfg_bits(MAX_WIDTH);
   localparam int HW = cfg_bits(MAX_HEIGHT);
   localparam int CW = cnt_bits(MAX_WIDTH);
   localparam int RW = cnt_bits(MAX_HEIGHT);

   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic          w_col_last;
   logic          w_row_last;

   // Coordinates are zero-extended by one bit to compare against the dimension.
   assign w_col_last = ({1'b0, r_col} == (i_width  - WW'(1)));
   assign w_row_last = ({1'b0, r_row} == (i_height - HW'(1)));

   assign o_col  = r_col;
   assign o_row  = r_row;
   assign o_last = w_col_last && w_row_last;

   // Advance one pixel per accepted beat; the final pixel wraps both back to 0.
   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         r_col <= '0;
         r_row <= '0;
      end else if (i_advance) begin
         if (w_col_last) begin
            r_col <= '0;
            r_row <= w_row_last ? '0 : r_row + RW'(1);
         end else begin
            r_col <= r_col + CW'(1);
         end
      end
   end

endmodule

// File: rtl/conv_window_ctrl.sv
// Frame controller for a 3x3 sliding window fed through a line buffer.
// Pixel handshake: a pixel is transferred on a cycle where i_px_valid and
// o_px_ready are both high; o_px_ready is high only while in RUN, and the
// line-buffer write strobe is that transfer, combinationally.
module conv_window_ctrl import conv_pkg::*; #(
   parameter int DATA_W     = 8,
   parameter int MAX_WIDTH  = 512,
   parameter int MAX_HEIGHT = 512
) (
   input  logic                            i_clk,
   input  logic                            i_reset,
   input  logic                            i_start,
   input  logic [cfg_bits(MAX_WIDTH)-1:0]  i_cfg_width,
   input  logic [cfg_bits(MAX_HEIGHT)-1:0] i_cfg_height,
   input  logic                            i_abort,
   input  logic                            i_px_valid,
   input  logic [DATA_W-1:0]               i_px_data,
   output logic                            o_px_ready,
   output logic                            o_lb_load_depth,
   output logic [cfg_bits(MAX_WIDTH)-1:0]  o_lb_depth,
   output logic                            o_lb_wr_valid,
   output logic [DATA_W-1:0]               o_lb_wr_data,
   output logic                            o_win_valid,
   output logic [cnt_bits(MAX_WIDTH)-1:0]  o_win_col,
   output logic [cnt_bits(MAX_HEIGHT)-1:0] o_win_row,
   output logic                            o_busy,
   output logic                            o_done,
   output logic                            o_cfg_err
);

   localparam int WW = cfg_bits(MAX_WIDTH);
   localparam int HW = cfg_bits(MAX_HEIGHT);
   localparam int CW = cnt_bits(MAX_WIDTH);
   localparam int RW = cnt_bits(MAX_HEIGHT);

   localparam logic [WW-1:0] MAX_W  = WW'(MAX_WIDTH);
   localparam logic [HW-1:0] MAX_H  = HW'(MAX_HEIGHT);
   localparam logic [WW-1:0] MIN_W  = WW'(WIN_SIZE);
   localparam logic [HW-1:0] MIN_H  = HW'(WIN_SIZE);
   localparam logic [CW-1:0] EDGE_C = CW'(WIN_SIZE - 1);
   localparam logic [RW-1:0] EDGE_R = RW'(WIN_SIZE - 1);

   conv_state_t    r_state;
   logic [WW-1:0]  r_width;
   logic [HW-1:0]  r_height;
   logic           r_load;
   logic           r_done;
   logic           r_cfg_err;
   logic           r_win_valid;
   logic [CW-1:0]  r_win_col;
   logic [RW-1:0]  r_win_row;

   logic           w_px_ready;
   logic           w_accept;
   logic           w_cfg_ok;
   logic           w_win_hit;
   logic           w_last;
   logic [CW-1:0]  w_col;
   logic [RW-1:0]  w_row;

   assign w_px_ready = (r_state == ST_RUN);
   assign w_accept   = i_px_valid && w_px_ready;
   assign w_cfg_ok   = (i_cfg_width  >= MIN_W) && (i_cfg_width  <= MAX_W) &&
                       (i_cfg_height >= MIN_H) && (i_cfg_height <= MAX_H);
   // A full 3x3 neighbourhood exists once two rows and two columns precede it.
   assign w_win_hit  = w_accept && (w_row >= EDGE_R) && (w_col >= EDGE_C);

   // Counters restart on abort and on every fresh frame load.
   frame_counter #(
      .MAX_WIDTH  (MAX_WIDTH),
      .MAX_HEIGHT (MAX_HEIGHT)
   ) u_frame_counter (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_clear    (i_abort || (r_state == ST_LOAD)),
      .i_advance  (w_accept),
      .i_width    (r_width),
      .i_height   (r_height),
      .o_col      (w_col),
      .o_row      (w_row),
      .o_last     (w_last)
   );

   // Frame FSM with registered pulse outputs and window tracking.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_width     <= MAX_W;
         r_height    <= MAX_H;
         r_load      <= 1'b0;
         r_done      <= 1'b0;
         r_cfg_err   <= 1'b0;
         r_win_valid <= 1'b0;
         r_win_col   <= '0;
         r_win_row   <= '0;
      end else begin
         r_load      <= 1'b0;
         r_done      <= 1'b0;
         r_cfg_err   <= 1'b0;
         r_win_valid <= 1'b0;
         if (i_abort) begin
            r_state <= ST_IDLE;
         end else begin
            if (w_win_hit) begin
               r_win_valid <= 1'b1;
               r_win_col   <= w_col;
               r_win_row   <= w_row;
            end
            case (r_state)
               ST_IDLE: begin
                  if (i_start) begin
                     if (w_cfg_ok) begin
                        r_width  <= i_cfg_width;
                        r_height <= i_cfg_height;
                        r_load   <= 1'b1;
                        r_state  <= ST_LOAD;
                     end else begin
                        r_cfg_err <= 1'b1;
                     end
                  end
               end
               ST_LOAD: r_state <= ST_RUN;
               ST_RUN: begin
                  if (w_accept && w_last) begin
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end
               end
               ST_DONE: r_state <= ST_IDLE;
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign o_px_ready      = w_px_ready;
   assign o_lb_wr_valid   = w_accept;
   assign o_lb_wr_data    = i_px_data;
   assign o_lb_load_depth = r_load;
   assign o_lb_depth      = r_width;
   assign o_win_valid     = r_win_valid;
   assign o_win_col       = r_win_col;
   assign o_win_row       = r_win_row;
   assign o_busy          = (r_state != ST_IDLE);
   assign o_done          = r_done;
   assign o_cfg_err       = r_cfg_err;

endmodule
